spi_ram_burst: RTL and testbench

- Parametrised SPI-slave-side RAM, next generation of the single-address command RAM.
- Takes the 2-bit command + payload word from the SPI slave deserialiser and returns read data to the serialiser.
- Keeps separate write and read address pointers, each auto-incrementing, so SPI bursts need no per-word address command.
- Has a registered read path with an explicit tx_valid pulse.

---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spi_ram_burst_mem.sv | 48 ++++
 rtl/spi_ram_burst.sv | 126 ++++++++++++
 tb/tb_spi_ram_burst.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes and read-FSM encoding for the SPI burst RAM.
package spi_ram_pkg;

    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/spi_ram_burst_mem.sv
// Storage array for spi_ram_burst: one write port, one synchronous read port
// whose output register holds its value until the next read.
module spi_ram_mem #(
    parameter int   MEM_DEPTH = 256,
    parameter int   WORD_W    = 8,
    localparam int  ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [MEM_DEPTH];
    logic [WORD_W-1:0] rd_data_d;
    logic [WORD_W-1:0] rd_data_q;

    // NOTE: the array has no reset branch so it maps onto RAM macros; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: the hold path is written out explicitly so the register never turns into a latch.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-slave-side RAM with auto-incrementing write/read pointers and a registered read path.
// Define SPI_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int   MEM_DEPTH = 256,
    parameter int   DATA_W    = 8,
    localparam int  ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              parity_err
);

`ifdef SPI_RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    rd_state_e         state_d, state_q;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign cmd     = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];

    // Out-of-range pointer loads fold back by one depth rather than saturating.
    function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} < DEPTH_EXT) begin
            return a;
        end
        return a - ADDR_W'(MEM_DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] incr(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        if (rx_valid) begin
            unique case (cmd)
                CMD_SET_WR: wr_ptr_d = fold(din[ADDR_W-1:0]);
                CMD_WRITE: begin
                    mem_wr_en = 1'b1;
                    wr_ptr_d  = incr(wr_ptr_q);
                end
                CMD_SET_RD: rd_ptr_d = fold(din[ADDR_W-1:0]);
                CMD_READ: begin
                    mem_rd_en = 1'b1;
                    rd_ptr_d  = incr(rd_ptr_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = mem_rd_en ? RESP : IDLE;
            RESP:    state_d = mem_rd_en ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef SPI_RAM_PARITY_EN
    // Even parity: the stored word including its parity bit always XORs to zero.
    assign wr_word    = {^payload, payload};
    assign parity_err = (state_q == RESP) && (^rd_word);
`else
    assign wr_word    = payload;
    assign parity_err = 1'b0;
`endif

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .WORD_W    (WORD_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    assign dout     = rd_word[DATA_W-1:0];
    assign tx_valid = (state_q == RESP);
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: a 256-word and a 200-word instance share one command bus.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;

    logic [7:0] dout,     dout_200;
    logic       tx_valid, tx_valid_200;
    logic [7:0] wr_ptr,   wr_ptr_200;
    logic [7:0] rd_ptr,   rd_ptr_200;
    logic       parity_err, parity_err_200;

    int n_cmp = 0;
    int n_err = 0;

    spi_ram_burst dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .rx_valid   (rx_valid),
        .dout       (dout),
        .tx_valid   (tx_valid),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .parity_err (parity_err)
    );

    spi_ram_burst #(.MEM_DEPTH(200)) dut_200 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .rx_valid   (rx_valid),
        .dout       (dout_200),
        .tx_valid   (tx_valid_200),
        .wr_ptr     (wr_ptr_200),
        .rd_ptr     (rd_ptr_200),
        .parity_err (parity_err_200)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d);
        rst      = r;
        rx_valid = v;
        din      = {c, d};
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; din = '0;

        // Reset then idle
        step(1'b1, 1'b0, CMD_SET_WR, 8'h00);
        step(1'b1, 1'b0, CMD_SET_WR, 8'h00);
        step(1'b0, 1'b0, CMD_SET_WR, 8'h00);
        check("rst_dout",      dout,       8'h00);
        check("rst_tx_valid",  tx_valid,   1'b0);
        check("rst_wr_ptr",    wr_ptr,     8'h00);
        check("rst_rd_ptr",    rd_ptr,     8'h00);
        check("rst_parity",    parity_err, 1'b0);
        check("rst_dout_200",  dout_200,   8'h00);

        // Burst write then back-to-back reads
        step(1'b0, 1'b1, CMD_SET_WR, 8'h10);
        step(1'b0, 1'b1, CMD_WRITE,  8'hA1);
        step(1'b0, 1'b1, CMD_WRITE,  8'hB2);
        step(1'b0, 1'b1, CMD_WRITE,  8'hC3);
        check("burst_wr_ptr",  wr_ptr,   8'h13);
        step(1'b0, 1'b1, CMD_SET_RD, 8'h10);
        check("burst_no_tx",   tx_valid, 1'b0);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("burst_rd0",     dout,     8'hA1);
        check("burst_tx0",     tx_valid, 1'b1);
        check("burst_par0",    parity_err, 1'b0);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("burst_rd1",     dout,     8'hB2);
        check("burst_tx1",     tx_valid, 1'b1);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("burst_rd2",     dout,     8'hC3);
        check("burst_tx2",     tx_valid, 1'b1);
        check("burst_rd_ptr",  rd_ptr,   8'h13);
        check("burst_wr_keep", wr_ptr,   8'h13);
        step(1'b0, 1'b0, CMD_SET_WR, 8'h00);
        check("burst_tx_drop", tx_valid, 1'b0);
        check("burst_hold",    dout,     8'hC3);

        // Wrap at 256; the 200-deep copy folds 0xFF to 0x37
        step(1'b0, 1'b1, CMD_SET_WR, 8'hFF);
        check("wrap_wr_ff",     wr_ptr,     8'hFF);
        check("fold_wr_200",    wr_ptr_200, 8'h37);
        step(1'b0, 1'b1, CMD_WRITE,  8'h55);
        check("wrap_wr_0",      wr_ptr,     8'h00);
        check("fold_wr_200_inc", wr_ptr_200, 8'h38);
        step(1'b0, 1'b1, CMD_WRITE,  8'h66);
        check("wrap_wr_1",      wr_ptr,     8'h01);
        step(1'b0, 1'b1, CMD_SET_RD, 8'hFF);
        check("fold_rd_200",    rd_ptr_200, 8'h37);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("wrap_rd_ff",     dout,       8'h55);
        check("wrap_rd_ptr0",   rd_ptr,     8'h00);
        check("fold_rd_200_d",  dout_200,   8'h55);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("wrap_rd_00",     dout,       8'h66);
        check("wrap_rd_ptr1",   rd_ptr,     8'h01);

        // Wrap at 199 on the 200-deep copy
        step(1'b0, 1'b1, CMD_SET_WR, 8'hC7);
        check("w200_set",       wr_ptr_200, 8'hC7);
        step(1'b0, 1'b1, CMD_WRITE,  8'h88);
        check("w200_wrap",      wr_ptr_200, 8'h00);
        check("w256_no_wrap",   wr_ptr,     8'hC8);
        step(1'b0, 1'b1, CMD_WRITE,  8'h99);
        check("w200_wr1",       wr_ptr_200, 8'h01);
        step(1'b0, 1'b1, CMD_SET_RD, 8'hC7);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("w200_rd_199",    dout_200,   8'h88);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("w200_rd_0",      dout_200,   8'h99);
        check("w200_rd_ptr",    rd_ptr_200, 8'h01);
        check("w200_tx",        tx_valid_200, 1'b1);
        check("w256_rd_ptr",    rd_ptr,     8'hC9);

        // Read-after-write on the same address
        step(1'b0, 1'b1, CMD_SET_RD, 8'h20);
        step(1'b0, 1'b1, CMD_SET_WR, 8'h20);
        step(1'b0, 1'b1, CMD_WRITE,  8'h77);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("raw_dout",       dout,     8'h77);
        check("raw_tx",         tx_valid, 1'b1);
        check("raw_wr_ptr",     wr_ptr,   8'h21);
        check("raw_rd_ptr",     rd_ptr,   8'h21);
        step(1'b0, 1'b0, CMD_SET_WR, 8'h00);
        check("raw_tx_drop",    tx_valid, 1'b0);
        check("raw_hold",       dout,     8'h77);

        // Command ignored while rx_valid is low
        step(1'b0, 1'b0, CMD_WRITE,  8'hEE);
        check("idle_wr_ptr",    wr_ptr,   8'h21);
        step(1'b0, 1'b0, CMD_READ,   8'h00);
        check("idle_no_tx",     tx_valid, 1'b0);
        check("idle_rd_ptr",    rd_ptr,   8'h21);

        // Reset in the cycle after a READ, with a READ also presented
        step(1'b0, 1'b1, CMD_SET_WR, 8'h00);
        step(1'b0, 1'b1, CMD_WRITE,  8'h5A);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        step(1'b1, 1'b1, CMD_READ,   8'h00);
        check("mrst_tx",        tx_valid, 1'b0);
        check("mrst_dout",      dout,     8'h00);
        check("mrst_wr_ptr",    wr_ptr,   8'h00);
        check("mrst_rd_ptr",    rd_ptr,   8'h00);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("mrst_rd_mem0",   dout,     8'h5A);
        check("mrst_rd_tx",     tx_valid, 1'b1);
        check("mrst_rd_ptr1",   rd_ptr,   8'h01);

`ifdef SPI_RAM_PARITY_EN
        step(1'b0, 1'b1, CMD_SET_WR, 8'h30);
        step(1'b0, 1'b1, CMD_WRITE,  8'h03);
        step(1'b0, 1'b1, CMD_WRITE,  8'h04);
        dut.u_mem.mem_q[8'h30][8] = ~dut.u_mem.mem_q[8'h30][8];
        step(1'b0, 1'b1, CMD_SET_RD, 8'h30);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("par_bad_dout",   dout,       8'h03);
        check("par_bad_tx",     tx_valid,   1'b1);
        check("par_bad_err",    parity_err, 1'b1);
        step(1'b0, 1'b1, CMD_READ,   8'h00);
        check("par_good_dout",  dout,       8'h04);
        check("par_good_err",   parity_err, 1'b0);
        step(1'b0, 1'b0, CMD_SET_WR, 8'h00);
        check("par_idle_err",   parity_err, 1'b0);
`else
        check("par_tied_low",   parity_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
